// File: rtl/uart_pkg.sv
// Shared UART character definitions: ASCII bounds, transform mode codes and the
// per-character case transform used on the pipe's write path.
package uart_pkg;

  localparam logic [6:0] UPPER_A    = 7'd65;
  localparam logic [6:0] UPPER_Z    = 7'd90;
  localparam logic [6:0] LOWER_A    = 7'd97;
  localparam logic [6:0] LOWER_Z    = 7'd122;
  localparam logic [6:0] CASE_DELTA = 7'd32;

  localparam logic [1:0] MODE_ECHO  = 2'd0;
  localparam logic [1:0] MODE_SWAP  = 2'd1;
  localparam logic [1:0] MODE_UPPER = 2'd2;
  localparam logic [1:0] MODE_LOWER = 2'd3;

  function automatic logic [6:0] char_xform(input logic [1:0] mode, input logic [6:0] c);
    logic is_up;
    logic is_lo;
    is_up      = (c >= UPPER_A) && (c <= UPPER_Z);
    is_lo      = (c >= LOWER_A) && (c <= LOWER_Z);
    char_xform = c;
    case (mode)
      MODE_SWAP: begin
        if (is_up)      char_xform = c + CASE_DELTA;
        else if (is_lo) char_xform = c - CASE_DELTA;
      end
      MODE_UPPER: if (is_lo) char_xform = c - CASE_DELTA;
      MODE_LOWER: if (is_up) char_xform = c + CASE_DELTA;
      default:    char_xform = c;
    endcase
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered head (no fall-through); the caller guarantees
// push only when not full or when popping in the same cycle. Flush clears occupancy.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [DATA_WIDTH-1:0]    wdata_i,
  output logic [DATA_WIDTH-1:0]    rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   fill_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_q, rd_q;
  logic [FW-1:0]         fill_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q   <= '0;
      rd_q   <= '0;
      fill_q <= '0;
    end else if (flush_i) begin
      wr_q   <= '0;
      rd_q   <= '0;
      fill_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + AW'(1);
      if (pop_i)  rd_q <= rd_q + AW'(1);
      case ({push_i, pop_i})
        2'b10:   fill_q <= fill_q + FW'(1);
        2'b01:   fill_q <= fill_q - FW'(1);
        default: fill_q <= fill_q;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (rst_n && !flush_i && push_i) mem_q[wr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_q];
  assign full_o  = (fill_q == FW'(DEPTH));
  assign empty_o = (fill_q == '0);
  assign fill_o  = fill_q;

endmodule

// File: rtl/uart_char_pipe.sv
// Buffered UART character transformer: case transform on enqueue, FIFO to the
// transmitter, back-pressure or drop-on-full, flush, and rx/tx/drop statistics.
module uart_char_pipe
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 8,
  parameter int CNT_WIDTH    = 16,
  parameter bit DROP_ON_FULL = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             mode,
  input  logic                   flush,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] fill,
  output logic [CNT_WIDTH-1:0]   rx_count,
  output logic [CNT_WIDTH-1:0]   tx_count,
  output logic [CNT_WIDTH-1:0]   drop_count
);

  logic                  full, empty, push, pop, drop;
  logic [DATA_WIDTH-1:0] xform_dat;
  logic [CNT_WIDTH-1:0]  rx_q, rx_d, tx_q, tx_d, drop_q, drop_d;

  assign pop      = !empty && out_ready;
  assign in_ready = DROP_ON_FULL ? 1'b1 : !full;
  // In drop mode a pop frees the slot the same cycle, so a full FIFO can still accept.
  assign push     = in_valid && (!full || (DROP_ON_FULL && pop));
  assign drop     = DROP_ON_FULL && in_valid && full && !pop;

  always_comb begin
    xform_dat = in_data;
    if (in_data[DATA_WIDTH-1:7] == '0) xform_dat[6:0] = char_xform(mode, in_data[6:0]);
  end

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .wdata_i (xform_dat),
    .rdata_o (out_data),
    .full_o  (full),
    .empty_o (empty),
    .fill_o  (fill)
  );

  always_comb begin
    rx_d   = rx_q;
    tx_d   = tx_q;
    drop_d = drop_q;
    if (!flush) begin
      if (push) rx_d = rx_q + CNT_WIDTH'(1);
      if (pop)  tx_d = tx_q + CNT_WIDTH'(1);
      if (drop && (drop_q != '1)) drop_d = drop_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_q   <= '0;
      tx_q   <= '0;
      drop_q <= '0;
    end else begin
      rx_q   <= rx_d;
      tx_q   <= tx_d;
      drop_q <= drop_d;
    end
  end

  assign out_valid  = !empty;
  assign rx_count   = rx_q;
  assign tx_count   = tx_q;
  assign drop_count = drop_q;

endmodule
